// File: rtl/issue_unit_if.sv
// Handshake bundle between issue_unit and its fetch memory, reservation stations,
// reorder buffer and commit redirect.
interface issue_unit_if #(
    parameter int WORD_SIZE = 32,
    parameter int FU_NUM    = 11,
    parameter int FU_INDEX  = 4
);
    logic                 imem_re;
    logic [WORD_SIZE-1:0] imem_addr;
    logic                 imem_valid;
    logic [WORD_SIZE-1:0] imem_data;
    logic [FU_NUM-1:0]    busy;
    logic                 rb_ready;
    logic                 issue_valid;
    logic [FU_INDEX-1:0]  issue_fu;
    logic [WORD_SIZE-1:0] issue_inst;
    logic [WORD_SIZE-1:0] issue_pc;
    logic                 flush;
    logic [WORD_SIZE-1:0] flush_pc;
    logic                 halted;

    modport master (
        output imem_re, imem_addr, issue_valid, issue_fu, issue_inst, issue_pc, halted,
        input  imem_valid, imem_data, busy, rb_ready, flush, flush_pc
    );

    modport slave (
        input  imem_re, imem_addr, issue_valid, issue_fu, issue_inst, issue_pc, halted,
        output imem_valid, imem_data, busy, rb_ready, flush, flush_pc
    );
endinterface

// File: rtl/issue_unit.sv
// In-order fetch/issue front end: fetches into a small circular queue and issues the
// head to the lowest free functional unit of its class, stopping at HALT.
module issue_unit #(
    parameter int WORD_SIZE  = 32,
    parameter int IQ_DEPTH   = 4,
    parameter int ADDER_NUM  = 3,
    parameter int MULTER_NUM = 2,
    parameter int LOADER_NUM = 3,
    parameter int BRANCH_NUM = 1,
    parameter int STORER_NUM = 2,
    parameter int FU_NUM     = ADDER_NUM + MULTER_NUM + LOADER_NUM + BRANCH_NUM + STORER_NUM,
    parameter int FU_INDEX   = 4
) (
    input logic          clk,
    input logic          reset,
    issue_unit_if.master bus
);
    localparam int MUL_BASE = ADDER_NUM;
    localparam int LD_BASE  = MUL_BASE + MULTER_NUM;
    localparam int BR_BASE  = LD_BASE + LOADER_NUM;
    localparam int ST_BASE  = BR_BASE + BRANCH_NUM;
    localparam int ST_END   = ST_BASE + STORER_NUM;
    localparam int PTR_W    = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int CNT_W    = $clog2(IQ_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(IQ_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(IQ_DEPTH);

    typedef enum logic [2:0] {CL_ADD, CL_MUL, CL_LD, CL_ST, CL_BR, CL_HALT} fu_class_e;

    function automatic fu_class_e decode_class(input logic [WORD_SIZE-1:0] inst);
        case (inst[WORD_SIZE-1 -: 3])
            3'b010:  return CL_MUL;
            3'b100:  return CL_LD;
            3'b101:  return CL_ST;
            3'b110:  return CL_BR;
            3'b111:  return CL_HALT;
            default: return CL_ADD;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] fetch_pc_q;
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 inflight_q, inflight_d;
    logic                 halt_seen_q, halt_seen_d;
    logic                 last_vld_q, last_vld_d;
    logic [FU_INDEX-1:0]  last_fu_q, last_fu_d;
    logic [WORD_SIZE-1:0] iq_inst_q [IQ_DEPTH];
    logic [WORD_SIZE-1:0] iq_pc_q   [IQ_DEPTH];

    logic                 not_empty;
    logic                 head_halt;
    logic                 sel_found;
    logic                 issue_ok;
    logic                 fetch;
    logic                 push;
    logic                 fire;
    logic [FU_INDEX-1:0]  sel_fu;
    logic [WORD_SIZE-1:0] head_inst;
    logic [WORD_SIZE-1:0] head_pc;
    logic [CNT_W:0]       occupancy;
    fu_class_e            head_class;
    int                   cls_lo;
    int                   cls_hi;

    assign not_empty  = (count_q != '0);
    assign head_inst  = iq_inst_q[head_q];
    assign head_pc    = iq_pc_q[head_q];
    assign head_class = decode_class(head_inst);
    assign head_halt  = not_empty && (head_class == CL_HALT);
    assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};

    always_comb begin
        cls_lo = 0;
        cls_hi = 0;
        case (head_class)
            CL_ADD:  begin cls_lo = 0;        cls_hi = MUL_BASE; end
            CL_MUL:  begin cls_lo = MUL_BASE; cls_hi = LD_BASE;  end
            CL_LD:   begin cls_lo = LD_BASE;  cls_hi = BR_BASE;  end
            CL_BR:   begin cls_lo = BR_BASE;  cls_hi = ST_BASE;  end
            CL_ST:   begin cls_lo = ST_BASE;  cls_hi = ST_END;   end
            default: begin cls_lo = 0;        cls_hi = 0;        end
        endcase
    end

    // busy lags one cycle, so the unit issued last cycle is excluded even if it reads free
    always_comb begin
        sel_found = 1'b0;
        sel_fu    = '0;
        for (int i = FU_NUM - 1; i >= 0; i--) begin
            if (i >= cls_lo && i < cls_hi && !bus.busy[i]
                && !(last_vld_q && last_fu_q == FU_INDEX'(i))) begin
                sel_found = 1'b1;
                sel_fu    = FU_INDEX'(i);
            end
        end
    end

    assign issue_ok = !reset && not_empty && !head_halt && sel_found;
    assign fire     = issue_ok && bus.rb_ready && !bus.flush;
    assign fetch    = !reset && !bus.flush && !head_halt && !halt_seen_q
                      && (occupancy < DEPTH_EXT);
    assign push     = !reset && !bus.flush && inflight_q && bus.imem_valid && !halt_seen_q;

    assign bus.imem_re     = fetch;
    assign bus.imem_addr   = reset ? '0 : pc_q;
    assign bus.issue_valid = issue_ok;
    assign bus.issue_fu    = issue_ok ? sel_fu : '0;
    assign bus.issue_inst  = (!reset && not_empty) ? head_inst : '0;
    assign bus.issue_pc    = (!reset && not_empty) ? head_pc : '0;
    assign bus.halted      = !reset && head_halt;

    always_comb begin
        pc_d        = pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        inflight_d  = 1'b0;
        halt_seen_d = halt_seen_q;
        last_vld_d  = 1'b0;
        last_fu_d   = last_fu_q;
        if (bus.flush) begin
            pc_d        = bus.flush_pc;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            halt_seen_d = 1'b0;
        end else begin
            inflight_d = fetch;
            if (fetch) begin
                pc_d = pc_q + WORD_SIZE'(4);
            end
            if (push) begin
                tail_d = ptr_inc(tail_q);
                if (decode_class(bus.imem_data) == CL_HALT) begin
                    halt_seen_d = 1'b1;
                end
            end
            if (fire) begin
                head_d = ptr_inc(head_q);
            end
            count_d    = count_q + CNT_W'(push) - CNT_W'(fire);
            last_vld_d = fire;
            last_fu_d  = sel_fu;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
            halt_seen_q <= 1'b0;
            last_vld_q  <= 1'b0;
            last_fu_q   <= '0;
        end else begin
            pc_q        <= pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            halt_seen_q <= halt_seen_d;
            last_vld_q  <= last_vld_d;
            last_fu_q   <= last_fu_d;
        end
    end

    // queue payload needs no reset: it is only observed while count_q says it is valid
    always_ff @(posedge clk) begin
        if (push) begin
            iq_inst_q[tail_q] <= bus.imem_data;
            iq_pc_q[tail_q]   <= fetch_pc_q;
        end
        if (fetch) begin
            fetch_pc_q <= pc_q;
        end
    end
endmodule

// File: doc/issue_unit.md
ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 Parameters: WORD_SIZE=32 (data/address width); IQ_DEPTH=4 (instruction queue entries); ADDER_NUM=3, MULTER_NUM=2, LOADER_NUM=3, BRANCH_NUM=1, STORER_NUM=2 (FU counts); FU_NUM = sum of counts; FU_INDEX=4 (FU index width).
REQ-002 FU index map SHALL be: adders [0..ADDER_NUM-1], then multers, then loaders, then branch, then storers occupying [FU_NUM-STORER_NUM..FU_NUM-1].
REQ-003 Ports, all synchronous to one clock; reset is synchronous and active-high:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- imem_re  out  1  instruction fetch request
- imem_addr  out  WORD_SIZE  fetch address (PC)
- imem_valid  in  1  fetch response valid, exactly 1 cycle after imem_re
- imem_data  in  WORD_SIZE  fetched instruction
- busy  in  FU_NUM  per-FU busy from reservation stations
- rb_ready  in  1  reorder buffer can accept an instruction this cycle
- issue_valid  out  1  head instruction issuable
- issue_fu  out  FU_INDEX  target FU index
- issue_inst  out  WORD_SIZE  instruction word
- issue_pc  out  WORD_SIZE  PC of issued instruction
- flush  in  1  mispredict/redirect from commit
- flush_pc  in  WORD_SIZE  redirect target
- halted  out  1  HALT reached queue head

Function
REQ-004 Class decode from inst[31:29]: 000/001 adder, 010 multer, 100 load, 101 store, 110 branch, 111 HALT; 011 SHALL be treated as adder.
REQ-005 Fetch: when not halted, not halt_seen, and count+inflight < IQ_DEPTH, imem_re=1, imem_addr=pc, pc <= pc+4 (mod 2^WORD_SIZE).
REQ-006 inflight is 1 for the cycle after a fetch request; imem_valid pushes imem_data with its PC into the queue tail.
REQ-007 Queue: circular FIFO, head/tail wrap modulo IQ_DEPTH; push and pop in same cycle leaves count unchanged; push never occurs when full (guaranteed by REQ-005).
REQ-008 Issue selection: lowest-index FU of head's class with busy=0 and not equal to the FU issued in the previous cycle (busy lags one cycle).
REQ-009 issue_valid = queue non-empty AND head not HALT AND a free FU exists; issue_fu/inst/pc combinational from head; issue_fu=0 when issue_valid=0.
REQ-010 fire = issue_valid AND rb_ready; on fire the head is popped; at most one issue per cycle.
REQ-011 A pushed HALT sets halt_seen (fetch stops); responses arriving after halt_seen is set are discarded; halted=1 while HALT is at head; HALT is never popped.
REQ-012 flush (highest priority): pc <= flush_pc; queue emptied; halt_seen, halted cleared; no fire, no fetch, no push that cycle; an in-flight response arriving next cycle is discarded.
REQ-013 Empty queue: issue_valid=0. No free FU for head class: head stalls, fetch continues until full.

Reset
REQ-014 On reset: pc=0, queue empty (head=tail=count=0), inflight=0, last-issued FU invalid, halt_seen=0; outputs imem_re=0, imem_addr=0, issue_valid=0, issue_fu=0, issue_inst=0, issue_pc=0, halted=0.
REQ-015 reset dominates flush and all other inputs; a response arriving the cycle after reset is discarded.

Verification
REQ-016 After reset, memory returns adder ops, busy=0, rb_ready=1 -> imem_addr 0,4,8...; first issue_valid 2 cycles after reset release, issue_fu=0, issue_pc=0; then one issue per cycle alternating FU 0/1 (REQ-008).
REQ-017 Four multer ops, busy[3]=busy[4]=1, rb_ready=1 -> issue_valid=0, queue fills to 4, imem_re drops to 0; releasing busy[4] -> issue_fu=4.
REQ-018 rb_ready=0 for 5 cycles with load at head -> issue_valid=1, issue_fu=5 held, no pop; rb_ready=1 -> pop, next head on following cycle.
REQ-019 Stream ADD, STORE, HALT, ADD -> store issues to FU 9, HALT reaches head, halted=1, imem_re=0, trailing ADD never enters queue.
REQ-020 Queue holding 3 entries, flush=1, flush_pc=0x40 -> next cycle queue empty, imem_addr=0x40, halted=0; stale response discarded.
